// File: rtl/mouse_pkg.sv
// Shared types and constants for the mouse button conditioning front end.
package mouse_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } debounce_state_t;

  localparam int DEFAULT_STABLE_CYCLES = 4;
  localparam int PRESS_COUNT_W         = 8;

endpackage

// File: rtl/mouse_debouncer_sync2.sv
// Single-bit two-flop synchroniser bringing an asynchronous level into the clock domain.
module sync2 (
  input  logic clock,
  input  logic reset_,
  input  logic d,
  output logic q
);

  logic meta_d, meta_q;
  logic sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/mouse_debouncer.sv
// Synchronises and debounces the raw mouse button, emitting press/release pulses,
// the debounced level and a wrapping press counter.
module mouse_debouncer
  import mouse_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
  input  logic                     clock,
  input  logic                     reset_,
  input  logic                     button_raw,
  input  logic                     enable,
  output logic                     mouse_pressed_,
  output logic                     mouse_released,
  output logic                     mouse_level,
  output logic [PRESS_COUNT_W-1:0] press_count
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic                     sync_q;
  debounce_state_t          state_d, state_q;
  logic [CNT_W-1:0]         cnt_d, cnt_q;
  logic                     pressed_d, pressed_q;
  logic                     released_d, released_q;
  logic                     level_d, level_q;
  logic [PRESS_COUNT_W-1:0] count_d, count_q;
  logic                     accept_press, accept_release;

  sync2 u_sync2 (
    .clock  (clock),
    .reset_ (reset_),
    .d      (button_raw),
    .q      (sync_q)
  );

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    accept_press   = 1'b0;
    accept_release = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      PRESS_WAIT: begin
        if (!sync_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d      = HELD;
          cnt_d        = '0;
          accept_press = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!sync_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      RELEASE_WAIT: begin
        // A return to 1 mid-count is treated as bounce on the held button.
        if (sync_q) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d        = IDLE;
          cnt_d          = '0;
          accept_release = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Suppressed pulses are dropped outright, never deferred or counted.
    pressed_d  = accept_press & enable;
    released_d = accept_release & enable;
    level_d    = (state_d == HELD) || (state_d == RELEASE_WAIT);
    count_d    = count_q + PRESS_COUNT_W'(pressed_d);
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pressed_q  <= 1'b0;
      released_q <= 1'b0;
      level_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
      level_q    <= level_d;
      count_q    <= count_d;
    end
  end

  assign mouse_pressed_ = pressed_q;
  assign mouse_released = released_q;
  assign mouse_level    = level_q;
  assign press_count    = count_q;

endmodule

// File: tb/tb_mouse_debouncer.sv
// Self-checking bench for mouse_debouncer: directed scenarios plus random bounce,
// compared every cycle against a run-length debounce model.
module tb_mouse_debouncer;

  localparam int S = 4;

  logic       clock;
  logic       reset_;
  logic       button_raw;
  logic       enable;
  logic       mouse_pressed_;
  logic       mouse_released;
  logic       mouse_level;
  logic [7:0] press_count;

  mouse_debouncer #(.STABLE_CYCLES(S)) dut (
    .clock          (clock),
    .reset_         (reset_),
    .button_raw     (button_raw),
    .enable         (enable),
    .mouse_pressed_ (mouse_pressed_),
    .mouse_released (mouse_released),
    .mouse_level    (mouse_level),
    .press_count    (press_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model: two-sample delay line, then a debounced level that flips
  // once S consecutive samples disagree with it.
  logic       m_s1, m_s2, m_lvl;
  int         m_run;
  logic       m_pressed, m_released;
  logic [7:0] m_count;

  int n_press = 0;
  int n_rel   = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_lvl = 0; m_run = 0;
    m_pressed = 0; m_released = 0; m_count = 0;
  endtask

  task automatic tick(input logic raw, input logic en);
    logic smp;
    button_raw = raw;
    enable     = en;
    smp  = m_s2;
    m_s2 = m_s1;
    m_s1 = raw;
    m_pressed  = 0;
    m_released = 0;
    if (smp != m_lvl) begin
      m_run++;
      if (m_run == S) begin
        m_lvl = smp;
        m_run = 0;
        if (en && smp) begin
          m_pressed = 1;
          m_count   = m_count + 8'd1;
        end
        if (en && !smp) m_released = 1;
      end
    end else begin
      m_run = 0;
    end
    @(posedge clock);
    #1;
    chk("pressed",  {7'd0, mouse_pressed_}, {7'd0, m_pressed});
    chk("released", {7'd0, mouse_released}, {7'd0, m_released});
    chk("level",    {7'd0, mouse_level},    {7'd0, m_lvl});
    chk("count",    press_count,            m_count);
    if (mouse_pressed_ === 1'b1) n_press++;
    if (mouse_released === 1'b1) n_rel++;
  endtask

  task automatic do_reset();
    #2;
    reset_ = 1'b0;
    #1;
    chk("rst_pressed",  {7'd0, mouse_pressed_}, 8'd0);
    chk("rst_released", {7'd0, mouse_released}, 8'd0);
    chk("rst_level",    {7'd0, mouse_level},    8'd0);
    chk("rst_count",    press_count,            8'd0);
    model_reset();
    @(negedge clock);
    reset_ = 1'b1;
  endtask

  initial begin
    int p0, r0, pulse_at;
    logic [7:0] c0;
    logic lvl;
    int hold;

    reset_     = 1'b0;
    button_raw = 1'b0;
    enable     = 1'b1;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    chk("reset_pressed",  {7'd0, mouse_pressed_}, 8'd0);
    chk("reset_released", {7'd0, mouse_released}, 8'd0);
    chk("reset_level",    {7'd0, mouse_level},    8'd0);
    chk("reset_count",    press_count,            8'd0);
    @(negedge clock);
    reset_ = 1'b1;
    repeat (3) tick(1'b0, 1'b1);

    // Clean press: pulse in the sixth cycle after raw rises (after E5).
    p0 = n_press; pulse_at = -1;
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 1'b1);
      if (mouse_pressed_ === 1'b1 && pulse_at < 0) pulse_at = i;
    end
    chk("clean_pulse_at", 8'(pulse_at), 8'd5);
    chk("clean_npulse",   8'(n_press - p0), 8'd1);
    chk("clean_level",    {7'd0, mouse_level}, 8'd1);
    chk("clean_count",    press_count, 8'd1);
    r0 = n_rel;
    repeat (20) tick(1'b0, 1'b1);
    chk("clean_nrel", 8'(n_rel - r0), 8'd1);

    // Bounce before a steady press.
    p0 = n_press; r0 = n_rel; pulse_at = -1;
    for (int i = 0; i < 24; i++) begin
      tick((i == 1 || i == 3) ? 1'b0 : 1'b1, 1'b1);
      if (mouse_pressed_ === 1'b1 && pulse_at < 0) pulse_at = i;
    end
    chk("bounce_pulse_at", 8'(pulse_at), 8'd9);
    chk("bounce_npulse",   8'(n_press - p0), 8'd1);
    chk("bounce_nrel",     8'(n_rel - r0), 8'd0);

    // Release glitch while held.
    p0 = n_press; r0 = n_rel;
    repeat (2) tick(1'b0, 1'b1);
    repeat (12) tick(1'b1, 1'b1);
    chk("glitch_nrel",   8'(n_rel - r0), 8'd0);
    chk("glitch_npress", 8'(n_press - p0), 8'd0);
    chk("glitch_level",  {7'd0, mouse_level}, 8'd1);
    repeat (10) tick(1'b0, 1'b1);

    // Enable gating over a full press/release.
    p0 = n_press; r0 = n_rel; c0 = press_count;
    repeat (10) tick(1'b1, 1'b0);
    chk("gate_level_hi", {7'd0, mouse_level}, 8'd1);
    repeat (10) tick(1'b0, 1'b0);
    chk("gate_level_lo", {7'd0, mouse_level}, 8'd0);
    chk("gate_npress",   8'(n_press - p0), 8'd0);
    chk("gate_nrel",     8'(n_rel - r0), 8'd0);
    chk("gate_count",    press_count, c0);

    // Random bounce, holds and enable toggling.
    lvl = 1'b0;
    for (int k = 0; k < 120; k++) begin
      lvl  = $urandom_range(0, 1);
      hold = $urandom_range(1, 8);
      for (int j = 0; j < hold; j++) tick(lvl, 1'($urandom_range(0, 3) != 0));
    end
    repeat (12) tick(1'b0, 1'b1);

    // Counter wrap over 256 presses starting from a fresh reset.
    do_reset();
    repeat (3) tick(1'b0, 1'b1);
    p0 = n_press;
    for (int k = 0; k < 256; k++) begin
      repeat (6) tick(1'b1, 1'b1);
      repeat (6) tick(1'b0, 1'b1);
      if (k == 254) chk("wrap_255", press_count, 8'd255);
    end
    chk("wrap_zero",   press_count, 8'd0);
    chk("wrap_npulse", 8'((n_press - p0) % 256), 8'd0);
    chk("wrap_nbig",   8'((n_press - p0) / 256), 8'd1);

    // Reset in PRESS_WAIT with cnt=2, then re-debounce with raw held high.
    repeat (4) tick(1'b1, 1'b1);
    do_reset();
    p0 = n_press; pulse_at = -1;
    for (int i = 0; i < 12; i++) begin
      tick(1'b1, 1'b1);
      if (mouse_pressed_ === 1'b1 && pulse_at < 0) pulse_at = i;
    end
    chk("rstmid_pulse_at", 8'(pulse_at), 8'd5);
    chk("rstmid_npulse",   8'(n_press - p0), 8'd1);
    chk("rstmid_count",    press_count, 8'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
